// File: rtl/dbus_pkg.sv
// Shared types and default address map for the core data-bus router.
package dbus_pkg;

  // Router transaction state: one outstanding access at most.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RAM = 2'd1,
    WAIT_IO  = 2'd2,
    ERR      = 2'd3
  } dbus_state_t;

  // Request target selected by the address decoder.
  typedef enum logic {
    TGT_RAM = 1'b0,
    TGT_IO  = 1'b1
  } dbus_tgt_t;

  // Default MMIO window: the whole 0x1xxx_xxxx region.
  localparam logic [31:0] DBUS_MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] DBUS_MMIO_MASK = 32'hF000_0000;

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational address decode: picks RAM vs MMIO and flags misaligned word
// accesses. Kept free of state so the instruction-side bus can share it.
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DBUS_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK = ADDR_W'(DBUS_MMIO_MASK)
) (
  input  logic [ADDR_W-1:0] addr,
  output dbus_tgt_t         tgt,
  output logic              misaligned
);

  assign tgt        = ((addr & MMIO_MASK) == MMIO_BASE) ? TGT_IO : TGT_RAM;
  // Only full-word accesses exist on this bus, so any low address bit is illegal.
  assign misaligned = |addr[1:0];

endmodule

// File: rtl/dbus_router.sv
// Data-bus router: forwards one core load/store at a time to RAM or MMIO,
// returns the owning target's response, rejects misaligned accesses locally
// and records any target response that arrives when nobody is waiting for it.
module dbus_router
  import dbus_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DBUS_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK = ADDR_W'(DBUS_MMIO_MASK)
) (
  input  logic                clk,
  input  logic                rst,
  // core side
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // RAM target
  output logic                ram_req_valid,
  input  logic                ram_req_ready,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  input  logic                ram_rsp_valid,
  input  logic [DATA_W-1:0]   ram_rsp_rdata,
  // MMIO target
  output logic                io_req_valid,
  input  logic                io_req_ready,
  output logic [ADDR_W-1:0]   io_addr,
  output logic                io_we,
  output logic [DATA_W-1:0]   io_wdata,
  output logic [DATA_W/8-1:0] io_wstrb,
  input  logic                io_rsp_valid,
  input  logic [DATA_W-1:0]   io_rsp_rdata,
  // diagnostics
  output logic                stray_rsp
);

  dbus_state_t state;
  dbus_tgt_t   tgt;
  logic        misaligned;
  logic        hs_ram;
  logic        hs_io;
  logic        hs_err;
  logic        stray_set;

  dbus_addr_decode #(
    .ADDR_W    (ADDR_W),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_MASK (MMIO_MASK)
  ) u_decode (
    .addr       (req_addr),
    .tgt        (tgt),
    .misaligned (misaligned)
  );

  // Payload goes to both targets unconditionally; only req_valid qualifies it.
  assign ram_addr  = req_addr;
  assign ram_we    = req_we;
  assign ram_wdata = req_wdata;
  assign ram_wstrb = req_wstrb;
  assign io_addr   = req_addr;
  assign io_we     = req_we;
  assign io_wdata  = req_wdata;
  assign io_wstrb  = req_wstrb;

  // Handshake qualifiers seen by the FSM (all gated off while in reset).
  assign hs_ram = !rst && (state == IDLE) && req_valid && !misaligned &&
                  (tgt == TGT_RAM) && ram_req_ready;
  assign hs_io  = !rst && (state == IDLE) && req_valid && !misaligned &&
                  (tgt == TGT_IO) && io_req_ready;
  assign hs_err = !rst && (state == IDLE) && req_valid && misaligned;

  // A response is stray whenever its target is not the one being waited on;
  // this includes late responses to a transaction killed by reset.
  assign stray_set = (ram_rsp_valid && (state != WAIT_RAM)) ||
                     (io_rsp_valid  && (state != WAIT_IO));

  // Request steering and response muxing; zero-time pass-through so the
  // router adds no cycles to target latency.
  always_comb begin
    req_ready     = 1'b0;
    ram_req_valid = 1'b0;
    io_req_valid  = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            req_ready = 1'b1;
          end else if (tgt == TGT_IO) begin
            io_req_valid = req_valid;
            req_ready    = io_req_ready;
          end else begin
            ram_req_valid = req_valid;
            req_ready     = ram_req_ready;
          end
        end
        WAIT_RAM: begin
          if (ram_rsp_valid) begin
            rsp_valid = 1'b1;
            rsp_rdata = ram_rsp_rdata;
          end
        end
        WAIT_IO: begin
          if (io_rsp_valid) begin
            rsp_valid = 1'b1;
            rsp_rdata = io_rsp_rdata;
          end
        end
        ERR: begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transaction FSM plus the sticky stray-response flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stray_rsp <= 1'b0;
    end else begin
      if (stray_set) stray_rsp <= 1'b1;
      case (state)
        IDLE: begin
          if (hs_err)      state <= ERR;
          else if (hs_io)  state <= WAIT_IO;
          else if (hs_ram) state <= WAIT_RAM;
        end
        WAIT_RAM: if (ram_rsp_valid) state <= IDLE;
        WAIT_IO:  if (io_rsp_valid)  state <= IDLE;
        ERR:      state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbus_router.md
# dbus_router

Steers core data-bus load/store requests to one of two targets: data RAM or the MMIO peripheral block. It carries exactly one outstanding transaction at a time and returns the owning target's response to the core. Misaligned word accesses are rejected with an error response and are never forwarded. The block sits between the core's load/store stage and the memory/peripheral side of the RISC-V datapath; it is the fan-out counterpart of the core's operand/result muxing.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed; strobe width is DATA_W/8)
- MMIO_BASE, 32'h1000_0000, MMIO region base
- MMIO_MASK, 32'hF000_0000, MMIO compare mask

Ports:
- clk, in, 1, the only clock; all state updates on the rising edge
- rst, in, 1, asynchronous, active-high reset
- req_valid / req_ready, in / out, 1 / 1, core request handshake
- req_addr, in, ADDR_W, byte address
- req_we, in, 1, 1 = store
- req_wdata, in, DATA_W, store data
- req_wstrb, in, 4, store byte enables
- rsp_valid, out, 1, response to core (no backpressure)
- rsp_rdata, out, DATA_W, load data
- rsp_err, out, 1, misaligned access
- ram_req_valid / ram_req_ready, out / in, 1 / 1, RAM handshake
- ram_addr, ram_we, ram_wdata, ram_wstrb, out, as for the core side, forwarded request
- ram_rsp_valid, ram_rsp_rdata, in, 1 / DATA_W, RAM response
- io_*, same set as ram_*, MMIO target
- stray_rsp, out, 1, sticky flag: a target responded while not being waited on

## Operation
- Decode: the target is MMIO when (req_addr & MMIO_MASK) == MMIO_BASE; otherwise RAM. An access is misaligned when req_addr[1:0] != 0.
- States: IDLE, WAIT_RAM, WAIT_IO, ERR.
- IDLE, aligned request:
  - The request is passed combinationally to the selected target only: its req_valid = req_valid, and addr/we/wdata/wstrb are forwarded. The other target's req_valid = 0.
  - req_ready = selected target's req_ready.
  - On handshake, go to WAIT_RAM or WAIT_IO.
- IDLE, misaligned request:
  - req_ready = 1; neither target sees the request.
  - On handshake, go to ERR.
- WAIT_x:
  - req_ready = 0.
  - When x_rsp_valid = 1: rsp_valid = 1 and rsp_rdata = x_rsp_rdata, in the same cycle. The next state is IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. The next state is IDLE.
- rsp_err = 0 in every state other than ERR. rsp_rdata = 0 whenever rsp_valid = 0.
- Stray responses:
  - Any ram_rsp_valid outside WAIT_RAM, or io_rsp_valid outside WAIT_IO, sets stray_rsp.
  - The stray response is dropped and the FSM state does not change.
  - stray_rsp clears only on rst.
- Targets must not respond in the cycle they accept a request; their latency is at least 1 cycle.

## Timing
- Reset values: state = IDLE, stray_rsp = 0.
- While rst = 1, all combinational outputs are forced to 0: req_ready, rsp_*, ram_req_valid, io_req_valid.
- Latency from core request handshake to rsp_valid:
  - misaligned: exactly 1 cycle;
  - aligned: target latency, with 0 added cycles.
- Throughput:
  - A new request can be accepted in the cycle after rsp_valid.
  - Back-to-back accesses to a 1-cycle target therefore complete one every 2 cycles.
- Reset during WAIT_x:
  - The FSM returns to IDLE immediately and no rsp_valid is issued.
  - The late target response that follows sets stray_rsp (required behaviour).
- Simultaneous ram_rsp_valid and io_rsp_valid in WAIT_RAM: the RAM response is delivered and the IO response sets stray_rsp.

## Structure
- Package dbus_pkg holds:
  - the state enum dbus_state_t (IDLE, WAIT_RAM, WAIT_IO, ERR);
  - the target enum dbus_tgt_t (TGT_RAM, TGT_IO);
  - default MMIO_BASE and MMIO_MASK constants.
- Sub-module dbus_addr_decode: purely combinational.
  - Inputs: addr.
  - Outputs: tgt (dbus_tgt_t) and misaligned.
  - It is reused by the instruction-side bus later.
- The top level holds the FSM, the forwarding/response muxing and the stray flag.

## Test plan
- Load at 0x0000_0040. RAM ready = 1, RAM responds 2 cycles later with 0xDEAD_BEEF. Required: rsp_valid in that same cycle with rdata 0xDEAD_BEEF and rsp_err = 0; io_req_valid never asserted.
- Store to 0x1000_0004 with wdata 0x0000_00A5 and wstrb 4'b0001. IO holds ready = 0 for 3 cycles. Required: req_ready low for those 3 cycles, forwarded fields stable, a single IO handshake, then rsp_valid when IO responds.
- Load at 0x0000_0042. Required: accepted immediately, rsp_valid = 1 with rsp_err = 1 and rdata = 0 exactly 1 cycle later, no target req_valid asserted.
- io_rsp_valid pulsed while idle. Required: stray_rsp rises the next cycle and stays high; a subsequent RAM load completes normally.
- rst pulsed during WAIT_RAM, then the RAM responds. Required: no rsp_valid, state IDLE, stray_rsp = 1. Then 4 back-to-back RAM loads with a 1-cycle RAM: one completes every 2 cycles with correct data.
